// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execute stage: select codes, FSM states and
// default widths.
package alu_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_ADDU = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        HOLD  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_arith_core.sv
// Combinational value/overflow for every select except SLL, which the
// sequencer handles itself.
module alu_arith_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] value,
    output logic             overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_signed;
    logic             lt_unsigned;

    assign sum         = a + b;
    assign diff        = a - b;
    assign lt_signed   = ($signed(a) < $signed(b));
    assign lt_unsigned = (a < b);

    // Select the operation result and its signed-overflow flag
    always_comb begin
        value    = {WIDTH{1'b0}};
        overflow = 1'b0;
        case (sel)
            ALU_AND:  value = a & b;
            ALU_OR:   value = a | b;
            ALU_ADD: begin
                value    = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT:  value = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_ADDU: value = sum;
            ALU_SUB: begin
                value    = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLTU: value = {{(WIDTH-1){1'b0}}, lt_unsigned};
            default:  value = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// ALU execute stage with valid/ready handshakes and registered result/flags.
// Define ALU_BARREL_SHIFT_EN for a one-cycle barrel SLL instead of the iterative shifter.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         sel,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow
);

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             load;
    logic             start_shift;
    logic             is_sll;
    logic             sll_multi;
    logic             load_ovf;
    logic             core_ovf;
    logic [WIDTH-1:0] core_value;
    logic [WIDTH-1:0] sll_value;
    logic [WIDTH-1:0] load_value;

    alu_arith_core #(.WIDTH(WIDTH)) u_core (
        .sel      (sel),
        .a        (a),
        .b        (b),
        .value    (core_value),
        .overflow (core_ovf)
    );

    assign is_sll = (sel == ALU_SLL);
    assign accept = in_valid && in_ready;

`ifdef ALU_BARREL_SHIFT_EN
    assign sll_multi = 1'b0;
    assign sll_value = a << shamt;
`else
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;

    // Only a zero shift amount bypasses the iterative shifter
    assign sll_multi = is_sll && (shamt != {SHAMT_W{1'b0}});
    assign sll_value = a;
`endif

    // Ready is free in IDLE and passes the consumer's ready through in HOLD
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Next state and result-register load control
    always_comb begin
        next_state  = state;
        load        = 1'b0;
        start_shift = 1'b0;
        load_value  = core_value;
        load_ovf    = core_ovf;
        if (accept) begin
            if (sll_multi) begin
                start_shift = 1'b1;
                next_state  = SHIFT;
            end else begin
                load       = 1'b1;
                next_state = HOLD;
                if (is_sll) begin
                    load_value = sll_value;
                    load_ovf   = 1'b0;
                end else begin
                    load_value = core_value;
                    load_ovf   = core_ovf;
                end
            end
        end else begin
            case (state)
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    if (cnt == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                        load       = 1'b1;
                        load_value = {acc[WIDTH-2:0], 1'b0};
                        load_ovf   = 1'b0;
                        next_state = HOLD;
                    end else begin
                        next_state = SHIFT;
                    end
                end
`endif
                HOLD: begin
                    if (out_ready) begin
                        next_state = IDLE;
                    end else begin
                        next_state = HOLD;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // State, result and flag registers; out_valid tracks entry into HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            result    <= {WIDTH{1'b0}};
            zero      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            out_valid <= (next_state == HOLD);
            if (load) begin
                result   <= load_value;
                zero     <= (load_value == {WIDTH{1'b0}});
                overflow <= load_ovf;
            end
        end
    end

`ifndef ALU_BARREL_SHIFT_EN
    // Iterative shifter: one bit per cycle, counter counts down to the final edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= {WIDTH{1'b0}};
            cnt <= {SHAMT_W{1'b0}};
        end else if (start_shift) begin
            acc <= a;
            cnt <= shamt;
        end else if (state == SHIFT) begin
            acc <= {acc[WIDTH-2:0], 1'b0};
            cnt <= cnt - {{(SHAMT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed cases plus randomized ops
// against a plain-arithmetic reference model.
module tb_alu_seq_exec;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int total;
    int bad;

    alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {overflow, result} from signed/unsigned arithmetic on wide integers
    function automatic logic [32:0] model(input logic [2:0] s, input logic [31:0] x,
                                          input logic [31:0] y, input logic [4:0] sh);
        longint sx;
        longint sy;
        longint r;
        logic [31:0] res;
        logic ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ov = 1'b0;
        res = 32'd0;
        case (s)
            3'd0: res = x & y;
            3'd1: res = x | y;
            3'd2: begin r = sx + sy; res = r[31:0]; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            3'd3: res = (sx < sy) ? 32'd1 : 32'd0;
            3'd4: res = x + y;
            3'd5: res = x << sh;
            3'd6: begin r = sx - sy; res = r[31:0]; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            default: res = ({32'd0, x} < {32'd0, y}) ? 32'd1 : 32'd0;
        endcase
        return {ov, res};
    endfunction

    function automatic int latency(input logic [2:0] s, input logic [4:0] sh);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        return (s == 3'd5 && sh != 5'd0) ? int'(sh) + 1 : 1;
`endif
    endfunction

    // Issue one op with out_ready=1 and check latency, result and flags
    task automatic do_op(input string name, input logic [2:0] s, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] sh);
        logic [32:0] exp;
        int n;
        int edges;
        exp = model(s, x, y, sh);
        out_ready = 1'b1;
        in_valid = 1'b1; sel = s; a = x; b = y; shamt = sh;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; shamt = 5'($urandom);
        edges = 1;
        while (!out_valid && edges < 100) begin
            @(posedge clk); #1; edges++;
        end
        total++;
        if (edges !== latency(s, sh)) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", name, edges, latency(s, sh));
        end
        total++;
        if (result !== exp[31:0]) begin
            bad++; $display("FAIL %s result: got %h want %h", name, result, exp[31:0]);
        end
        total++;
        if (zero !== (exp[31:0] == 32'd0)) begin
            bad++; $display("FAIL %s zero: got %b want %b", name, zero, exp[31:0] == 32'd0);
        end
        total++;
        if (overflow !== exp[32]) begin
            bad++; $display("FAIL %s overflow: got %b want %b", name, overflow, exp[32]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sel = 3'd0; a = 32'd0; b = 32'd0; shamt = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, result, zero, overflow} !== 35'd0) begin
            bad++; $display("FAIL reset_outputs: got v=%b r=%h z=%b o=%b want all 0", out_valid, result, zero, overflow);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_arith();
        do_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1, 5'd0);
        do_op("sub_zero", 3'b110, 32'd5, 32'd5, 5'd0);
        do_op("addu_wrap", 3'b100, 32'hFFFF_FFFF, 32'd1, 5'd0);
        do_op("slt", 3'b011, 32'hFFFF_FFFF, 32'd1, 5'd0);
        do_op("sltu", 3'b111, 32'hFFFF_FFFF, 32'd1, 5'd0);
        do_op("sub_ovf", 3'b110, 32'h8000_0000, 32'd1, 5'd0);
        do_op("and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    endtask

    task automatic test_sll();
        int busy;
        int edges;
        do_op("sll_0", 3'b101, 32'h0000_00A5, 32'd0, 5'd0);
        do_op("sll_1", 3'b101, 32'h8000_0001, 32'd0, 5'd1);
        out_ready = 1'b1;
        in_valid = 1'b1; sel = 3'b101; a = 32'd1; shamt = 5'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy = 0; edges = 1;
        while (!out_valid && edges < 100) begin
            if (!in_ready) busy++;
            @(posedge clk); #1; edges++;
        end
        total++;
        if (busy !== latency(3'b101, 5'd31) - 1) begin
            bad++; $display("FAIL sll31_busy: got %0d want %0d", busy, latency(3'b101, 5'd31) - 1);
        end
        total++;
        if (edges !== latency(3'b101, 5'd31) || result !== 32'h8000_0000) begin
            bad++; $display("FAIL sll31: got edges=%0d result=%h want %0d/80000000", edges, result, latency(3'b101, 5'd31));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int n;
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 3'b010; a = 32'd100; b = 32'd23;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        held = result;
        total++;
        if (held !== 32'd123) begin
            bad++; $display("FAIL bp_first: got %h want %h", held, 32'd123);
        end
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            total++;
            if (result !== 32'd123 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold: got r=%h v=%b rdy=%b want 0000007b/1/0", result, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        in_valid = 1'b1; sel = 3'b001; a = 32'hF0; b = 32'h0F;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || result !== 32'hFF) begin
            bad++; $display("FAIL bp_next: got v=%b r=%h want 1/000000ff", out_valid, result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [2:0] s;
        logic [32:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s = 3'($urandom_range(0, 7));
            if (s == 3'd5) s = 3'd4;
            in_valid = 1'b1; sel = s; a = $urandom; b = $urandom; shamt = 5'($urandom);
            exp = model(s, a, b, shamt);
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || result !== exp[31:0] || overflow !== exp[32]) begin
                bad++; $display("FAIL b2b_%0d: got v=%b r=%h o=%b want 1/%h/%b", i, out_valid, result, overflow, exp[31:0], exp[32]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [2:0] s;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 30; i++) begin
            s = 3'($urandom_range(0, 7));
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? x : $urandom;
            if ($urandom_range(0, 3) == 0) x[31] = y[31];
            do_op("rand", s, x, y, 5'($urandom));
        end
    endtask

    task automatic test_reset_mid_shift();
        int spurious;
        out_ready = 1'b1;
        in_valid = 1'b1; sel = 3'b101; a = 32'h0000_0003; shamt = 5'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 32'd0) begin
            bad++; $display("FAIL mid_rst: got v=%b r=%h want 0/00000000", out_valid, result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_rst_ready: got %b want 1", in_ready);
        end
        spurious = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        total++;
        if (spurious !== 0) begin
            bad++; $display("FAIL mid_rst_spurious: got %0d pulses want 0", spurious);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_arith();
        test_sll();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
